output_port: RTL and testbench

//  Consumer end of the MCU OUT instruction. Captures the 16-bit word presented

---
 rtl/output_port_if.sv | 18 +
 rtl/output_port.sv | 119 +++++++++++
 tb/tb_output_port.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/output_port_if.sv
// rtl/output_port_if.sv - byte-wide valid/ready link from output_port to the external sink
interface output_port_if;
    logic       ext_valid;
    logic [7:0] ext_byte;
    logic       ext_ready;

    modport master (
        output ext_valid,
        output ext_byte,
        input  ext_ready
    );

    modport slave (
        input  ext_valid,
        input  ext_byte,
        output ext_ready
    );
endinterface

// File: rtl/output_port.sv
// rtl/output_port.sv - OUT-instruction word FIFO drained high byte first to a byte sink
module output_port #(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              output_valid,
    input  logic [15:0]       out_data,
    input  logic              clear_overflow,
    output_port_if.master     ext,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow
);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    state_t state, state_n;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [7:0]        hold_lo;
    logic [15:0]       head;
    logic              pop, push, drop;
    logic              valid_q, valid_n;
    logic [7:0]        byte_q, byte_n;

    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign ext.ext_valid = valid_q;
    assign ext.ext_byte  = byte_q;

    // A full FIFO still accepts a push when the serializer pops on the same edge.
    assign push = output_valid && (!fifo_full || pop);
    assign drop = output_valid && !push;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = SEND_HI;
                end
            end
            SEND_HI: begin
                if (ext.ext_ready) state_n = SEND_LO;
            end
            SEND_LO: begin
                if (ext.ext_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = SEND_HI;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output byte is registered so it stays stable until the sink takes it.
    always_comb begin
        valid_n = (state_n != IDLE);
        byte_n  = byte_q;
        if (pop)
            byte_n = head[15:8];
        else if (state == SEND_HI && ext.ext_ready)
            byte_n = hold_lo;
        else if (state_n == IDLE)
            byte_n = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
            hold_lo <= 8'h00;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            byte_q  <= byte_n;
            if (pop) hold_lo <= head[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_output_port.sv
// tb/tb_output_port.sv - scoreboard bench for output_port
module tb_output_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        output_valid;
    logic [15:0] out_data;
    logic        clear_overflow;
    logic [3:0]  fifo_count;
    logic        fifo_full, fifo_empty, overflow;

    output_port_if ext_if();

    output_port #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .output_valid   (output_valid),
        .out_data       (out_data),
        .clear_overflow (clear_overflow),
        .ext            (ext_if),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    int cyc = 0;
    int first_valid_cyc = -1;
    int last_hs_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted byte is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ext_if.ext_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ext_if.ext_ready) begin
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, ext_if.ext_byte}, 32'hFFFF_FFFF);
                end else begin
                    chk("byte", {24'h0, ext_if.ext_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input bit accept);
        output_valid = 1'b1;
        out_data     = w;
        if (accept) begin
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        tick();
        output_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(fifo_empty && !ext_if.ext_valid) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, n < 200, 1);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        output_valid = 1'b0;
        out_data = 16'h0;
        clear_overflow = 1'b0;
        ext_if.ext_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", ext_if.ext_valid, 0);
        chk("rst_byte", ext_if.ext_byte, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);

        // T1 single word, latency and valid width
        ext_if.ext_ready = 1'b1;
        push(16'hA55A, 1);
        chk("t1_valid_e0", ext_if.ext_valid, 0);
        chk("t1_count_e0", fifo_count, 1);
        tick();
        chk("t1_valid_e1", ext_if.ext_valid, 1);
        chk("t1_byte_hi", ext_if.ext_byte, 8'hA5);
        tick();
        chk("t1_valid_e2", ext_if.ext_valid, 1);
        chk("t1_byte_lo", ext_if.ext_byte, 8'h5A);
        tick();
        chk("t1_valid_e3", ext_if.ext_valid, 0);
        drain("t1");

        // T2 backpressure
        ext_if.ext_ready = 1'b0;
        push(16'h1234, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", ext_if.ext_valid, 1);
            chk("t2_hold_byte", ext_if.ext_byte, 8'h12);
            tick();
        end
        ext_if.ext_ready = 1'b1;
        drain("t2");

        // T3 fill and overflow
        ext_if.ext_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i), 1);
        chk("t3_count_after8", fifo_count, 7);
        chk("t3_full_after8", fifo_full, 0);
        push(16'h0009, 1);
        chk("t3_count_after9", fifo_count, 8);
        chk("t3_full_after9", fifo_full, 1);
        chk("t3_ovf_before_drop", overflow, 0);
        push(16'h00AA, 0);
        chk("t3_ovf_drop", overflow, 1);
        chk("t3_count_drop", fifo_count, 8);
        clear_overflow = 1'b1;
        push(16'h00BB, 0);
        chk("t3_drop_beats_clear", overflow, 1);
        tick();
        clear_overflow = 1'b0;
        chk("t3_ovf_cleared", overflow, 0);

        // T4 push into a full FIFO on the same edge as a SEND_LO pop
        chk("t4_in_send_hi", ext_if.ext_byte, 8'h00);
        ext_if.ext_ready = 1'b1;
        tick();
        chk("t4_in_send_lo", ext_if.ext_byte, 8'h01);
        push(16'h000A, 1);
        chk("t4_count_full", fifo_count, 8);
        chk("t4_ovf", overflow, 0);
        drain("t4");

        // T5 streaming with pointer wrap; one word every two cycles keeps the link busy
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            push({8'h10 + 8'(i), 8'hF0 - 8'(i)}, 1);
            tick();
        end
        drain("t5");
        chk("t5_span", last_hs_cyc - first_valid_cyc + 1, 40);
        chk("t5_count", fifo_count, 0);

        // T6 reset mid-word
        ext_if.ext_ready = 1'b0;
        push(16'hC1D1, 1);
        push(16'hC2D2, 1);
        push(16'hC3D3, 1);
        chk("t6_send_hi", ext_if.ext_byte, 8'hC1);
        ext_if.ext_ready = 1'b1;
        tick();
        ext_if.ext_ready = 1'b0;
        chk("t6_send_lo", ext_if.ext_byte, 8'hD1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("t6_valid", ext_if.ext_valid, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_empty", fifo_empty, 1);
        chk("t6_byte", ext_if.ext_byte, 0);
        push(16'hBEEF, 1);
        ext_if.ext_ready = 1'b1;
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
